// File: rtl/x_mul_y.sv
// ---------------------------------------------------------------------------
// x_mul_y : sequential 16x16 unsigned shift-and-add multiplier.
//
// One partial product is added per clock. Operands are captured when start is
// accepted, and every run takes exactly 16 iterations. The 32-bit product is
// written to out on the completion edge and held, with ready high, until the
// next accepted start.
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous, active-low reset
//   start  in   1  multiply request, accepted only in IDLE or DONE
//   x      in  16  multiplicand, sampled on the accepting edge
//   y      in  16  multiplier, sampled on the accepting edge
//   out    out 32  product register
//   ready  out  1  out holds the product of the most recent accepted start
//   busy   out  1  iteration sequence running
//
// State | meaning
// IDLE  | out of reset, waiting for start
// RUN   | iterating, one partial product per edge, start ignored
// DONE  | product valid on out, start restarts immediately
// ---------------------------------------------------------------------------
module x_mul_y (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] out,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] out_q, out_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic [31:0] sum;

    // Both operands fit in 16 bits, so the running sum never exceeds 32 bits.
    assign sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        out_d    = out_q;
        ready_d  = ready_q;
        busy_d   = busy_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    cnt_d    = 4'd0;
                    acc_d    = 32'd0;
                    mcand_d  = {16'd0, x};
                    mplier_d = y;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                cnt_d    = cnt_q + 4'd1;
                // The last iteration writes its sum straight to out so the
                // product appears on the 16th edge, not one edge later.
                if (cnt_q == 4'd15) begin
                    out_d   = sum;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 16'd0;
            out_q    <= 32'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_x_mul_y.sv
// ---------------------------------------------------------------------------
// tb_x_mul_y : directed self-checking bench for x_mul_y.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_x_mul_y;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] out;
    logic        ready;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    x_mul_y dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .out   (out),
        .ready (ready),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One complete run. disturb > 0 raises start and scrambles x/y from that
    // iteration onward, dropping start again before the completion edge.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] prev, input int disturb);
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        x = a; y = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_ready", {31'd0, ready}, 32'd0);
        check("accept_out_prev", out, prev);
        for (int i = 1; i <= 15; i++) begin
            if (disturb > 0 && i >= disturb && i < 15) begin
                start = 1'b1;
                if (i == disturb) begin
                    x = 16'd1000; y = 16'd1000;
                end else begin
                    x = 16'($urandom); y = 16'($urandom);
                end
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("iter%0d_busy", i), {31'd0, busy}, 32'd1);
            check($sformatf("iter%0d_ready", i), {31'd0, ready}, 32'd0);
            check($sformatf("iter%0d_out_held", i), out, prev);
        end
        @(posedge clk);
        @(negedge clk);
        check("done_ready", {31'd0, ready}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_out", out, exp);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; x = 16'd0; y = 16'd0;
        #1;
        check("rst_out", out, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic product
        run_mul(16'd123, 16'd11, 32'd0, 0);
        // Held in DONE without start
        @(negedge clk);
        check("done_hold_out", out, 32'd1353);
        check("done_hold_ready", {31'd0, ready}, 32'd1);

        // Back-to-back: start held high in DONE for two accepts
        x = 16'd2; y = 16'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready_drop", {31'd0, ready}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_out_prev", out, 32'd1353);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_iter%0d_out", i), out, 32'd1353);
            check($sformatf("b2b_iter%0d_busy", i), {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        // start was high on the completion edge and must have been ignored
        check("b2b_done_out", out, 32'd6);
        check("b2b_done_ready", {31'd0, ready}, 32'd1);
        check("b2b_done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
        check("b2b_reaccept_ready", {31'd0, ready}, 32'd0);
        check("b2b_reaccept_out", out, 32'd6);
        repeat (15) @(negedge clk);
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("b2b_second_out", out, 32'd6);
        check("b2b_second_ready", {31'd0, ready}, 32'd1);

        // Extreme and zero operands
        run_mul(16'hFFFF, 16'hFFFF, 32'd6, 0);
        run_mul(16'd0, 16'd500, 32'hFFFE0001, 0);
        run_mul(16'd500, 16'd0, 32'd0, 0);
        run_mul(16'd1234, 16'd567, 32'd0, 0);

        // Ignored restart and operand changes during RUN
        run_mul(16'd7, 16'd9, 32'd699678, 5);

        // Asynchronous reset mid-run
        @(negedge clk);
        x = 16'd300; y = 16'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rmid_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rmid_out", out, 32'd0);
        check("rmid_ready", {31'd0, ready}, 32'd0);
        check("rmid_busy_clr", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        check("post_rst_idle_out", out, 32'd0);

        // First start after reset release is accepted normally
        run_mul(16'd5000, 16'd13, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
